// File: rtl/memory_stage.sv
// RV32I MEM stage: byte-lane data memory with a one-cycle registered load path.
// Loads are aligned and extended in WB; misaligned accesses raise a flag instead.
module memory_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_store_data_i,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic [2:0]            MEM_funct3_i,
  output logic [DATA_WIDTH-1:0] WB_load_data_o,
  output logic                  WB_misaligned_o
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic [3:0][7:0] r_mem [DMEM_DEPTH];

  logic [AW-1:0]   w_idx;
  logic [1:0]      w_off;
  logic            w_is_b;
  logic            w_is_h;
  logic            w_is_w;
  logic            w_mis;
  logic [3:0]      w_be;
  logic [3:0]      w_we;
  logic [31:0]     w_wlanes;
  logic            w_unused;

  logic            r_valid;
  logic            r_mis;
  logic [3:0][7:0] r_word;
  logic [1:0]      r_off;
  logic [2:0]      r_f3;

  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign w_idx = MEM_alu_result_i[AW+1:2];
  assign w_off = MEM_alu_result_i[1:0];

  // Upper address bits are dropped so addresses wrap over the memory size.
  assign w_unused = &{1'b0, MEM_alu_result_i[DATA_WIDTH-1:AW+2]};

  assign w_is_b = (MEM_funct3_i == 3'b000) || (MEM_funct3_i == 3'b100);
  assign w_is_h = (MEM_funct3_i == 3'b001) || (MEM_funct3_i == 3'b101);
  assign w_is_w = (MEM_funct3_i == 3'b010);

  always_comb begin
    w_be  = 4'b0000;
    w_mis = 1'b0;
    unique case (1'b1)
      w_is_b: w_be = 4'b0001 << w_off;
      w_is_h: begin
        w_mis = w_off[0];
        w_be  = w_off[1] ? 4'b1100 : 4'b0011;
      end
      w_is_w: begin
        w_mis = |w_off;
        w_be  = 4'b1111;
      end
      default: begin
        w_be  = 4'b0000;
        w_mis = 1'b0;
      end
    endcase
  end

  // Replicate narrow store data so every enabled lane sees its own bytes.
  always_comb begin
    w_wlanes = MEM_store_data_i[31:0];
    unique case (1'b1)
      w_is_b:  w_wlanes = {4{MEM_store_data_i[7:0]}};
      w_is_h:  w_wlanes = {2{MEM_store_data_i[15:0]}};
      default: w_wlanes = MEM_store_data_i[31:0];
    endcase
  end

  assign w_we = w_be & {4{MEM_MemWrite_i & ~w_mis & rst_n}};

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (w_we[l]) begin
        r_mem[w_idx][l] <= w_wlanes[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      r_word  <= '0;
      r_off   <= 2'b00;
      r_f3    <= 3'b000;
    end else begin
      r_valid <= MEM_MemRead_i & ~MEM_MemWrite_i & ~w_mis;
      r_mis   <= (MEM_MemRead_i | MEM_MemWrite_i) & w_mis;
      r_off   <= w_off;
      r_f3    <= MEM_funct3_i;
      if (MEM_MemRead_i) begin
        r_word <= r_mem[w_idx];
      end else begin
        r_word <= '0;
      end
    end
  end

  assign w_byte = r_word[r_off];
  assign w_half = r_off[1] ? {r_word[3], r_word[2]}
                           : {r_word[1], r_word[0]};

  always_comb begin
    WB_load_data_o = '0;
    if (r_valid && rst_n) begin
      unique case (r_f3)
        3'b000: WB_load_data_o =
          {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
        3'b100: WB_load_data_o =
          {{(DATA_WIDTH-8){1'b0}}, w_byte};
        3'b001: WB_load_data_o =
          {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        3'b101: WB_load_data_o =
          {{(DATA_WIDTH-16){1'b0}}, w_half};
        3'b010: WB_load_data_o = DATA_WIDTH'(r_word);
        default: WB_load_data_o = '0;
      endcase
    end
  end

  // Outputs are forced low whenever reset is held, even before the edge.
  assign WB_misaligned_o = r_mis & rst_n;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: vector table plus reset sequence.
// Each vector is checked one cycle after it is applied.
module tb_memory_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] ldata;
  logic        mis;

  int checks;
  int errors;

  memory_stage #(
    .DATA_WIDTH(32),
    .DMEM_DEPTH(1024)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .MEM_alu_result_i (addr),
    .MEM_store_data_i (wdata),
    .MEM_MemRead_i    (re),
    .MEM_MemWrite_i   (we),
    .MEM_funct3_i     (f3),
    .WB_load_data_o   (ldata),
    .WB_misaligned_o  (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_d;
    logic        exp_m;
  } vec_t;

  localparam int NV = 32;
  vec_t v [NV];

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;
  localparam logic [2:0] X3 = 3'b011;

  task automatic check(input string nm,
                       input logic [31:0] ed,
                       input logic em);
    checks++;
    if (ldata !== ed || mis !== em) begin
      errors++;
      $display("FAIL %s: got data=%h mis=%b, want data=%h mis=%b",
               nm, ldata, mis, ed, em);
    end
  endtask

  task automatic drive(input logic w, input logic r,
                       input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] d);
    we = w; re = r; f3 = f; addr = a; wdata = d;
  endtask

  task automatic setv(input int i, input string nm,
                      input logic w, input logic r,
                      input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] ed, input logic em);
    v[i] = '{nm, w, r, f, a, d, ed, em};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    setv(0,  "sw_dead",   1, 0, W,  32'h100, 32'hDEADBEEF, 0, 0);
    setv(1,  "lw_dead",   0, 1, W,  32'h100, 0, 32'hDEADBEEF, 0);
    setv(2,  "sw_1122",   1, 0, W,  32'h100, 32'h11223344, 0, 0);
    setv(3,  "sb_80",     1, 0, B,  32'h101, 32'hAAAAAA80, 0, 0);
    setv(4,  "lb_101",    0, 1, B,  32'h101, 0, 32'hFFFFFF80, 0);
    setv(5,  "lbu_101",   0, 1, BU, 32'h101, 0, 32'h00000080, 0);
    setv(6,  "lw_after_sb", 0, 1, W, 32'h100, 0, 32'h11228044, 0);
    setv(7,  "sw_8001",   1, 0, W,  32'h100, 32'h80011234, 0, 0);
    setv(8,  "lh_102",    0, 1, H,  32'h102, 0, 32'hFFFF8001, 0);
    setv(9,  "lhu_102",   0, 1, HU, 32'h102, 0, 32'h00008001, 0);
    setv(10, "lh_100",    0, 1, H,  32'h100, 0, 32'h00001234, 0);
    setv(11, "sw_mis",    1, 0, W,  32'h102, 32'hCAFEF00D, 0, 1);
    setv(12, "lh_mis",    0, 1, H,  32'h103, 0, 0, 1);
    setv(13, "lw_unchg",  0, 1, W,  32'h100, 0, 32'h80011234, 0);
    setv(14, "sh_102",    1, 0, H,  32'h102, 32'h1234BEEF, 0, 0);
    setv(15, "lw_after_sh", 0, 1, W, 32'h100, 0, 32'hBEEF1234, 0);
    setv(16, "idle",      0, 0, W,  32'h100, 0, 0, 0);
    setv(17, "sw_wrap",   1, 0, W,  32'h1000, 32'h5A5A5A5A, 0, 0);
    setv(18, "lw_wrap",   0, 1, W,  32'h0000, 0, 32'h5A5A5A5A, 0);
    setv(19, "rw_both",   1, 1, W,  32'h104, 32'h01020304, 0, 0);
    setv(20, "lw_104",    0, 1, W,  32'h104, 0, 32'h01020304, 0);
    setv(21, "rw_mis",    1, 1, W,  32'h105, 32'hFFFFFFFF, 0, 1);
    setv(22, "lb_107",    0, 1, B,  32'h107, 0, 32'h00000001, 0);
    setv(23, "ld_f3_011", 0, 1, X3, 32'h104, 0, 0, 0);
    setv(24, "st_f3_011", 1, 0, X3, 32'h104, 32'hFFFFFFFF, 0, 0);
    setv(25, "lw_104b",   0, 1, W,  32'h104, 0, 32'h01020304, 0);
    setv(26, "sb_f0",     1, 0, B,  32'h106, 32'h000000F0, 0, 0);
    setv(27, "lbu_106",   0, 1, BU, 32'h106, 0, 32'h000000F0, 0);
    setv(28, "lb_106",    0, 1, B,  32'h106, 0, 32'hFFFFFFF0, 0);
    setv(29, "lhu_106",   0, 1, HU, 32'h106, 0, 32'h000001F0, 0);
    setv(30, "lw_mis",    0, 1, W,  32'h105, 0, 0, 1);
    setv(31, "idle_clr",  0, 0, B,  32'h0,   0, 0, 0);

    rst_n = 1'b0;
    drive(1, 1, W, 32'h100, 32'h12345678);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 0, 0);
    rst_n = 1'b1;
    drive(0, 0, B, 0, 0);
    @(negedge clk);
    check("post_reset_idle", 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(v[i].we, v[i].re, v[i].f3, v[i].addr, v[i].wdata);
      @(posedge clk);
      @(negedge clk);
      check(v[i].name, v[i].exp_d, v[i].exp_m);
    end

    // Reset sequence: a store under reset must not land in memory.
    drive(1, 0, W, 32'h200, 32'h0);
    @(negedge clk);
    drive(0, 1, W, 32'h200, 0);
    @(negedge clk);
    check("lw_200_zero", 0, 0);
    drive(0, 1, W, 32'h100, 0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1, 0, W, 32'h200, 32'hFFFFFFFF);
    #1;
    check("load_before_rst", 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("during_rst", 0, 0);
    end
    rst_n = 1'b1;
    drive(0, 0, W, 0, 0);
    @(negedge clk);
    check("rst_release", 0, 0);
    drive(0, 1, W, 32'h200, 0);
    @(negedge clk);
    check("lw_200_after_rst", 0, 0);
    drive(0, 1, W, 32'h100, 0);
    @(negedge clk);
    check("lw_100_after_rst", 32'hBEEF1234, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
